// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and FSM encoding for the UART receiver
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    localparam int CPB_MIN  = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_DONE      = 3'd5,
        ST_WAIT_IDLE = 3'd6
    } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchroniser, resets to the idle-high level
module uart_sync2 (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_gen.sv
// rtl/uart_rx_gen.sv - configurable-format UART receiver with parity/framing/break reporting
module uart_rx_gen
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int CNT_W     = 16
) (
    input  logic                 i_Clock,
    input  logic                 i_Rst_L,
    input  logic [CNT_W-1:0]     i_Clks_Per_Bit,
    input  logic                 i_Rx_Serial,
    output logic                 o_Rx_DV,
    output logic [DATA_BITS-1:0] o_Rx_Byte,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Break,
    output logic                 o_Busy
);

    rx_state_t            state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [CNT_W-1:0]     cpb_q, cpb_n;
    logic [3:0]           idx, idx_n;
    logic [DATA_BITS-1:0] word, word_n;
    logic                 pbit, pbit_n;
    logic                 ferr, ferr_n;
    logic                 all_zero, all_zero_n;
    logic                 rx_s;
    logic                 bit_end;
    logic                 half_hit;
    logic                 perr;

    uart_sync2 u_sync (
        .clk    (i_Clock),
        .resetn (i_Rst_L),
        .d      (i_Rx_Serial),
        .q      (rx_s)
    );

    assign bit_end  = (cnt == cpb_q - CNT_W'(1));
    assign half_hit = (cnt == ((cpb_q - CNT_W'(1)) >> 1));
    assign o_Busy   = (state != ST_IDLE);

    always_comb begin
        if (PARITY == PAR_EVEN)
            perr = ^word ^ pbit;
        else if (PARITY == PAR_ODD)
            perr = ~(^word ^ pbit);
        else
            perr = 1'b0;
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_L) begin
            state    <= ST_WAIT_IDLE;
            cnt      <= '0;
            cpb_q    <= '0;
            idx      <= '0;
            word     <= '0;
            pbit     <= 1'b0;
            ferr     <= 1'b0;
            all_zero <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            cpb_q    <= cpb_n;
            idx      <= idx_n;
            word     <= word_n;
            pbit     <= pbit_n;
            ferr     <= ferr_n;
            all_zero <= all_zero_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        cpb_n      = cpb_q;
        idx_n      = idx;
        word_n     = word;
        pbit_n     = pbit;
        ferr_n     = ferr;
        all_zero_n = all_zero;
        case (state)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_n = ST_START;
                    cnt_n   = '0;
                    // Divisors below the minimum are clamped so the counter compares stay sane.
                    cpb_n   = (i_Clks_Per_Bit < CNT_W'(CPB_MIN)) ? CNT_W'(CPB_MIN) : i_Clks_Per_Bit;
                end
            end
            ST_START: begin
                if (half_hit) begin
                    cnt_n      = '0;
                    idx_n      = '0;
                    ferr_n     = 1'b0;
                    all_zero_n = 1'b1;
                    state_n    = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    cnt_n      = '0;
                    // LSB arrives first, so shifting in from the top leaves it at bit 0.
                    word_n     = {rx_s, word[DATA_BITS-1:1]};
                    all_zero_n = all_zero & ~rx_s;
                    if (idx == 4'(DATA_BITS - 1)) begin
                        idx_n   = '0;
                        state_n = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        idx_n = idx + 4'd1;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    cnt_n      = '0;
                    pbit_n     = rx_s;
                    all_zero_n = all_zero & ~rx_s;
                    idx_n      = '0;
                    state_n    = ST_STOP;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    cnt_n      = '0;
                    ferr_n     = ferr | ~rx_s;
                    all_zero_n = all_zero & ~rx_s;
                    if (idx == 4'(STOP_BITS - 1))
                        state_n = ST_DONE;
                    else
                        idx_n = idx + 4'd1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_n = rx_s ? ST_IDLE : ST_WAIT_IDLE;
            end
            ST_WAIT_IDLE: begin
                if (rx_s)
                    state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_WAIT_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_L) begin
            o_Rx_DV      <= 1'b0;
            o_Rx_Byte    <= '0;
            o_Parity_Err <= 1'b0;
            o_Frame_Err  <= 1'b0;
            o_Break      <= 1'b0;
        end else begin
            o_Rx_DV <= (state == ST_DONE);
            if (state == ST_DONE) begin
                o_Rx_Byte    <= word;
                o_Parity_Err <= perr;
                o_Frame_Err  <= ferr & ~all_zero;
                o_Break      <= all_zero;
            end else begin
                o_Parity_Err <= 1'b0;
                o_Frame_Err  <= 1'b0;
                o_Break      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_gen.sv
// tb/tb_uart_rx_gen.sv - randomized self-checking bench for uart_rx_gen over four frame formats
module tb_uart_rx_gen;
    import uart_pkg::*;

    // Instance formats: 0 = 8N1, 1 = 7E1, 2 = 8N2, 3 = 9O2
    localparam logic [15:0] NB_P  = {4'd9, 4'd8, 4'd7, 4'd8};
    localparam logic [7:0]  PAR_P = {2'd2, 2'd0, 2'd1, 2'd0};
    localparam logic [7:0]  NS_P  = {2'd2, 2'd2, 2'd1, 2'd1};

    typedef struct {
        int         inst;
        logic [8:0] word;
        logic       pe;
        logic       fe;
        logic       brk;
        int         cyc;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_l;
    logic [15:0] cpb_in;
    logic        rx_line [4];
    logic        dv_w [4];
    logic        pe_w [4];
    logic        fe_w [4];
    logic        brk_w [4];
    logic        busy_w [4];
    logic [8:0]  word_w [4];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    ev_t         evq [$];
    ev_t         expq [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int NB = int'(NB_P[g*4 +: 4]);
        localparam int PR = int'(PAR_P[g*2 +: 2]);
        localparam int NS = int'(NS_P[g*2 +: 2]);
        logic [NB-1:0] w;

        uart_rx_gen #(.DATA_BITS(NB), .PARITY(PR), .STOP_BITS(NS), .CNT_W(16)) u_dut (
            .i_Clock        (clk),
            .i_Rst_L        (rst_l),
            .i_Clks_Per_Bit (cpb_in),
            .i_Rx_Serial    (rx_line[g]),
            .o_Rx_DV        (dv_w[g]),
            .o_Rx_Byte      (w),
            .o_Parity_Err   (pe_w[g]),
            .o_Frame_Err    (fe_w[g]),
            .o_Break        (brk_w[g]),
            .o_Busy         (busy_w[g])
        );

        assign word_w[g] = 9'(w);

        always @(negedge clk) begin
            if (dv_w[g]) begin
                ev_t e;
                e.inst = g;
                e.word = 9'(w);
                e.pe   = pe_w[g];
                e.fe   = fe_w[g];
                e.brk  = brk_w[g];
                e.cyc  = cyc;
                evq.push_back(e);
            end
        end
    end

    function automatic int fmt_nb(input int i);
        return int'(NB_P[i*4 +: 4]);
    endfunction

    function automatic int fmt_par(input int i);
        return int'(PAR_P[i*2 +: 2]);
    endfunction

    function automatic int fmt_ns(input int i);
        return int'(NS_P[i*2 +: 2]);
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference: a frame is start + data (LSB first) + optional parity + stop bits,
    // each held cpb clocks; strobe lands one clock after the centre of the last stop bit.
    task automatic send_frame(input int inst, input logic [8:0] data, input logic pflip,
                              input logic [1:0] stops);
        int         nb, par, ns, cpb, nbits, c0;
        logic [15:0] bits;
        logic [8:0] dm;
        logic       all0, pb;
        ev_t        e;
        nb    = fmt_nb(inst);
        par   = fmt_par(inst);
        ns    = fmt_ns(inst);
        cpb   = int'(cpb_in);
        c0    = cyc;
        dm    = data & ((9'h1 << nb) - 9'h1);
        bits  = '0;
        bits[0] = 1'b0;
        for (int i = 0; i < nb; i++) bits[1+i] = dm[i];
        nbits = 1 + nb;
        if (par != PAR_NONE) begin
            pb = (($countones(dm) % 2) == 1);
            if (par == PAR_ODD) pb = ~pb;
            bits[nbits] = pb ^ pflip;
            nbits++;
        end
        for (int j = 0; j < ns; j++) begin
            bits[nbits] = stops[j];
            nbits++;
        end
        all0 = 1'b1;
        for (int k = 1; k < nbits; k++) if (bits[k]) all0 = 1'b0;
        e.inst = inst;
        e.word = dm;
        e.pe   = (par != PAR_NONE) && pflip;
        e.fe   = ((ns == 2) ? ~(stops[0] & stops[1]) : ~stops[0]) & ~all0;
        e.brk  = all0;
        e.cyc  = c0 + 5 + (cpb - 1) / 2 + (nbits - 1) * cpb;
        expq.push_back(e);
        for (int k = 0; k < nbits; k++) begin
            rx_line[inst] = bits[k];
            step(cpb);
        end
        rx_line[inst] = 1'b1;
    endtask

    task automatic compare_events(input string tag);
        int n;
        check({tag, " count"}, evq.size(), expq.size());
        n = (evq.size() < expq.size()) ? evq.size() : expq.size();
        for (int i = 0; i < n; i++) begin
            check({tag, " inst"}, evq[i].inst, expq[i].inst);
            check({tag, " word"}, int'(evq[i].word), int'(expq[i].word));
            check({tag, " parity_err"}, int'(evq[i].pe), int'(expq[i].pe));
            check({tag, " frame_err"}, int'(evq[i].fe), int'(expq[i].fe));
            check({tag, " break"}, int'(evq[i].brk), int'(expq[i].brk));
            check({tag, " dv_cycle"}, evq[i].cyc, expq[i].cyc);
        end
        evq.delete();
        expq.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        for (int g = 0; g < 4; g++) begin
            check({tag, " dv"}, int'(dv_w[g]), 0);
            check({tag, " byte"}, int'(word_w[g]), 0);
            check({tag, " flags"}, int'({pe_w[g], fe_w[g], brk_w[g]}), 0);
        end
    endtask

    initial begin
        int   c0, inst, cpb;
        ev_t  e;
        rst_l  = 1'b0;
        cpb_in = 16'd16;
        for (int i = 0; i < 4; i++) rx_line[i] = 1'b1;

        step(3);
        check_outputs_zero("reset");
        rst_l = 1'b1;
        step(3);
        for (int g = 0; g < 4; g++) check("idle busy", int'(busy_w[g]), 0);

        // 8N1 basic frame and strobe latency
        send_frame(0, 9'h0A5, 1'b0, 2'b11);
        step(32);
        compare_events("8n1_a5");

        // 7E1 good then bad parity
        cpb_in = 16'd10;
        send_frame(1, 9'h035, 1'b0, 2'b11);
        send_frame(1, 9'h035, 1'b1, 2'b11);
        step(20);
        compare_events("7e1_parity");

        // 8N2 second stop bit low
        cpb_in = 16'd8;
        send_frame(2, 9'h03C, 1'b0, 2'b01);
        step(20);
        compare_events("8n2_frame_err");

        // Break: line low for 20 bit times gives exactly one strobe
        cpb_in = 16'd16;
        c0 = cyc;
        rx_line[0] = 1'b0;
        e.inst = 0; e.word = 9'h000; e.pe = 1'b0; e.fe = 1'b0; e.brk = 1'b1;
        e.cyc  = c0 + 5 + 7 + 9 * 16;
        expq.push_back(e);
        step(20 * 16);
        rx_line[0] = 1'b1;
        step(32);
        compare_events("break");
        send_frame(0, 9'h069, 1'b0, 2'b11);
        step(32);
        compare_events("after_break");

        // 5-clock glitch is rejected
        c0 = cyc;
        rx_line[0] = 1'b0;
        step(5);
        check("glitch busy_high", int'(busy_w[0]), 1);
        rx_line[0] = 1'b1;
        step(c0 + 12 - cyc);
        check("glitch busy_low", int'(busy_w[0]), 0);
        step(40);
        compare_events("glitch");

        // Back-to-back burst; divisor change during the first frame applies from the next one
        fork
            begin
                send_frame(0, 9'h000, 1'b0, 2'b11);
                send_frame(0, 9'h0FF, 1'b0, 2'b11);
                send_frame(0, 9'h081, 1'b0, 2'b11);
            end
            begin
                step(40);
                cpb_in = 16'd20;
            end
        join
        step(40);
        compare_events("burst");

        // Reset during data bit 3 with the line low abandons the frame
        cpb_in = 16'd16;
        rx_line[0] = 1'b0;
        step(16 + 3 * 16 + 8);
        rst_l = 1'b0;
        step(1);
        check_outputs_zero("mid_reset");
        step(1);
        rst_l = 1'b1;
        rx_line[0] = 1'b1;
        step(48);
        compare_events("mid_reset");
        send_frame(0, 9'h05A, 1'b0, 2'b11);
        step(32);
        compare_events("after_reset");

        // Randomized frames across all formats
        for (int n = 0; n < 40; n++) begin
            logic [8:0] d;
            logic       pf;
            logic [1:0] st;
            inst   = int'($urandom_range(0, 3));
            cpb    = int'($urandom_range(4, 24));
            cpb_in = 16'(cpb);
            d      = 9'($urandom);
            pf     = (fmt_par(inst) != PAR_NONE) ? 1'($urandom_range(0, 1)) : 1'b0;
            st[0]  = ($urandom_range(0, 3) != 0);
            st[1]  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) begin
                d  = 9'h000;
                st = 2'b00;
            end
            send_frame(inst, d, pf, st);
            step(int'($urandom_range(2, cpb)));
        end
        step(40);
        compare_events("random");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
